fpga_ddr3_example_if0_dmaster_pkt_arbiter: RTL and testbench

Packet-aware round-robin arbiter that shares the debug-master Avalon-ST byte path between NUM_CHANNELS requesting packet streams. Once a packet starts, it holds the grant until that packet's endofpacket beat, so packets never interleave. It emits the granted index on out_channel, feeding the packets-to-bytes channel adapter. One registered output stage with full valid/ready handshake.

---
 rtl/fpga_ddr3_example_if0_dmaster_pkt_pkg.sv | 25 ++
 rtl/fpga_ddr3_example_if0_dmaster_rr_arbiter.sv | 32 +++
 rtl/fpga_ddr3_example_if0_dmaster_pkt_arbiter.sv | 139 +++++++++++++
 tb/tb_fpga_ddr3_example_if0_dmaster_pkt_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_ddr3_example_if0_dmaster_pkt_pkg.sv
// Shared definitions for the debug-master packet arbiter: FSM encoding,
// index width and small index helpers.
package fpga_ddr3_example_if0_dmaster_pkt_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Index registers are sized for the largest supported channel count.
   localparam int unsigned MAX_CHANNELS = 8;
   localparam int unsigned IDX_WIDTH    = clog2(MAX_CHANNELS);

   function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx,
                                                      input int unsigned n);
      if (32'(idx) == n - 1) return '0;
      return idx + IDX_WIDTH'(1);
   endfunction

endpackage

// File: rtl/fpga_ddr3_example_if0_dmaster_rr_arbiter.sv
// Combinational rotating-priority select: first requester at or above
// rr_ptr, wrapping around.
module fpga_ddr3_example_if0_dmaster_rr_arbiter
   import fpga_ddr3_example_if0_dmaster_pkt_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 2
) (
   input  logic [NUM_CHANNELS-1:0] req,
   input  logic [IDX_WIDTH-1:0]    rr_ptr,
   output logic [NUM_CHANNELS-1:0] gnt_onehot,
   output logic [IDX_WIDTH-1:0]    gnt_idx,
   output logic                    any
);

   always_comb begin
      int unsigned c;
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      c          = 0;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
         c = 32'(rr_ptr) + k;
         if (c >= NUM_CHANNELS) c = c - NUM_CHANNELS;
         if (!any && req[c]) begin
            any           = 1'b1;
            gnt_idx       = IDX_WIDTH'(c);
            gnt_onehot[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpga_ddr3_example_if0_dmaster_pkt_arbiter.sv
// Packet-aware round-robin arbiter onto a single Avalon-ST byte path; a
// granted channel keeps the path until its endofpacket beat is accepted.
module fpga_ddr3_example_if0_dmaster_pkt_arbiter
   import fpga_ddr3_example_if0_dmaster_pkt_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS  = 2,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned CHANNEL_WIDTH = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CHANNELS-1:0]            in_valid,
   output logic [NUM_CHANNELS-1:0]            in_ready,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CHANNELS-1:0]            in_startofpacket,
   input  logic [NUM_CHANNELS-1:0]            in_endofpacket,
   input  logic                               out_ready,
   output logic                               out_valid,
   output logic [DATA_WIDTH-1:0]              out_data,
   output logic                               out_startofpacket,
   output logic                               out_endofpacket,
   output logic [CHANNEL_WIDTH-1:0]           out_channel
);

   logic [0:0]              state, state_next;
   logic [IDX_WIDTH-1:0]    rr_ptr, rr_next;
   logic [IDX_WIDTH-1:0]    lock_idx, lock_next;
   logic [NUM_CHANNELS-1:0] gnt_onehot;
   logic [IDX_WIDTH-1:0]    gnt_idx;
   logic                    any;
   logic                    space;
   logic [NUM_CHANNELS-1:0] ready_vec;
   logic                    accept;
   logic [DATA_WIDTH-1:0]   beat_data;
   logic                    beat_sop;
   logic                    beat_eop;
   logic [IDX_WIDTH-1:0]    beat_idx;

   fpga_ddr3_example_if0_dmaster_rr_arbiter #(
      .NUM_CHANNELS(NUM_CHANNELS)
   ) u_rr (
      .req       (in_valid),
      .rr_ptr    (rr_ptr),
      .gnt_onehot(gnt_onehot),
      .gnt_idx   (gnt_idx),
      .any       (any)
   );

   assign space    = ~out_valid | out_ready;
   assign in_ready = ready_vec;

   // Only the granted (IDLE) or locked channel may see ready.
   always_comb begin
      ready_vec = '0;
      if (!reset && space) begin
         if (state == ST_IDLE) begin
            if (any) ready_vec = gnt_onehot;
         end else begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++)
               if (lock_idx == IDX_WIDTH'(i)) ready_vec[i] = 1'b1;
         end
      end
   end

   // ready_vec is one-hot, so at most one beat matches here.
   always_comb begin
      accept    = 1'b0;
      beat_data = '0;
      beat_sop  = 1'b0;
      beat_eop  = 1'b0;
      beat_idx  = '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         if (ready_vec[i] && in_valid[i]) begin
            accept    = 1'b1;
            beat_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            beat_sop  = in_startofpacket[i];
            beat_eop  = in_endofpacket[i];
            beat_idx  = IDX_WIDTH'(i);
         end
      end
   end

   always_comb begin
      state_next = state;
      rr_next    = rr_ptr;
      lock_next  = lock_idx;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (beat_eop) begin
                  rr_next = next_idx(gnt_idx, NUM_CHANNELS);
               end else begin
                  lock_next  = gnt_idx;
                  state_next = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            if (accept && beat_eop) begin
               state_next = ST_IDLE;
               rr_next    = next_idx(lock_idx, NUM_CHANNELS);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         lock_idx <= '0;
      end else begin
         state    <= state_next;
         rr_ptr   <= rr_next;
         lock_idx <= lock_next;
      end
   end

   // Single output register stage; holds while downstream stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_channel       <= '0;
      end else if (accept) begin
         out_valid         <= 1'b1;
         out_data          <= beat_data;
         out_startofpacket <= beat_sop;
         out_endofpacket   <= beat_eop;
         out_channel       <= CHANNEL_WIDTH'(beat_idx);
      end else if (space) begin
         out_valid         <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fpga_ddr3_example_if0_dmaster_pkt_arbiter.sv
// Bench for the packet arbiter: per-channel packet sources, a packet-level
// round-robin reference model and directed plus randomized scenarios.
module tb_fpga_ddr3_example_if0_dmaster_pkt_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_startofpacket;
   logic [3:0]  in_endofpacket;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [7:0]  out_channel;

   fpga_ddr3_example_if0_dmaster_pkt_arbiter #(
      .NUM_CHANNELS (4),
      .DATA_WIDTH   (8),
      .CHANNEL_WIDTH(8)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .in_startofpacket (in_startofpacket),
      .in_endofpacket   (in_endofpacket),
      .out_ready        (out_ready),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_startofpacket(out_startofpacket),
      .out_endofpacket  (out_endofpacket),
      .out_channel      (out_channel)
   );

   always #5 clk = ~clk;

   int n_pass;
   int n_total;

   // Sources: beats are {sop, eop, data}; valid held until taken.
   logic [9:0] srcq[4][$];
   logic [3:0] src_vld;
   int         log_key[$];

   // Reference model: owner channel (-1 = none), search pointer, output reg.
   int         m_owner;
   int         m_ptr;
   bit         m_ov;
   logic [7:0] m_od;
   bit         m_sop;
   bit         m_eop;
   int         m_ch;

   task automatic model_clear();
      m_owner = -1; m_ptr = 0; m_ov = 0; m_od = '0; m_sop = 0; m_eop = 0; m_ch = 0;
      src_vld = '0;
      for (int i = 0; i < 4; i++) srcq[i].delete();
      log_key.delete();
   endtask

   function automatic bit pending();
      bit p;
      p = m_ov;
      for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic add_pkt(input int ch, input int len, input logic [7:0] d0, input logic [7:0] stp);
      for (int k = 0; k < len; k++)
         srcq[ch].push_back({(k == 0), (k == len - 1), 8'(d0 + 8'(k) * stp)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = '0; in_data = '0; in_startofpacket = '0; in_endofpacket = '0;
      out_ready = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock: drive at negedge, check ready before the edge, outputs after.
   task automatic step(input bit ordy, input int vpct);
      logic [3:0] exp_rdy;
      logic [9:0] b;
      int         g;
      int         c;
      bit         space;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         if (!src_vld[i] && srcq[i].size() > 0 && int'($urandom_range(99)) < vpct)
            src_vld[i] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b = (srcq[i].size() > 0) ? srcq[i][0] : 10'd0;
         in_valid[i]         = src_vld[i];
         in_data[i*8 +: 8]   = b[7:0];
         in_startofpacket[i] = b[9];
         in_endofpacket[i]   = b[8];
      end
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) log_key.push_back(int'(out_channel) * 256 + int'(out_data));
      space = !m_ov || ordy;
      g = -1;
      if (m_owner < 0) begin
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (g < 0 && src_vld[c]) g = c;
         end
      end else begin
         g = m_owner;
      end
      exp_rdy = '0;
      if (g >= 0 && space) exp_rdy[g] = 1'b1;
      n_total++;
      if (in_ready !== exp_rdy)
         $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
      else n_pass++;
      if (g >= 0 && space && src_vld[g]) begin
         b = srcq[g].pop_front();
         src_vld[g] = 1'b0;
         m_ov = 1; m_od = b[7:0]; m_sop = b[9]; m_eop = b[8]; m_ch = g;
         if (b[8]) begin
            m_owner = -1;
            m_ptr   = (g + 1) % 4;
         end else begin
            m_owner = g;
         end
      end else if (space) begin
         m_ov = 0;
      end
      @(posedge clk);
      #1;
      n_total++;
      if (out_valid !== m_ov)
         $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, m_ov);
      else n_pass++;
      if (m_ov) begin
         n_total++;
         if (out_data !== m_od || out_startofpacket !== m_sop || out_endofpacket !== m_eop ||
             out_channel !== 8'(m_ch))
            $display("FAIL out_beat t=%0t got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", $time,
                     out_data, out_startofpacket, out_endofpacket, out_channel,
                     m_od, m_sop, m_eop, m_ch);
         else n_pass++;
      end
   endtask

   task automatic drain(input int rpct, input int vpct, input int budget, output int cyc);
      cyc = 0;
      while (pending() && cyc < budget) begin
         step(int'($urandom_range(99)) < rpct, vpct);
         cyc++;
      end
      n_total++;
      if (pending()) $display("FAIL drain_timeout cycles=%0d limit=%0d", cyc, budget);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 4'hF; in_data = 32'hDEAD_BEEF;
      in_startofpacket = 4'hF; in_endofpacket = 4'h0; out_ready = 1'b1;
      model_clear();
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_total++;
      if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
      n_total++;
      if (out_startofpacket !== 1'b0 || out_endofpacket !== 1'b0)
         $display("FAIL reset_sop_eop got=%b%b exp=00", out_startofpacket, out_endofpacket);
      else n_pass++;
      n_total++;
      if (out_channel !== 8'h00) $display("FAIL reset_out_channel got=%h exp=00", out_channel); else n_pass++;
      n_total++;
      if (in_ready !== 4'h0) $display("FAIL reset_in_ready got=%b exp=0000", in_ready); else n_pass++;
      @(negedge clk);
      in_valid = '0;
      reset = 1'b0;
      step(1'b1, 100);
   endtask

   task automatic test_single_back_to_back();
      int cyc;
      int exp_k[3] = '{'h011, 'h022, 'h033};
      do_reset();
      add_pkt(0, 3, 8'h11, 8'h11);
      drain(100, 100, 50, cyc);
      n_total++;
      if (log_key.size() != 3) $display("FAIL b2b_count got=%0d exp=3", log_key.size()); else n_pass++;
      for (int k = 0; k < 3 && k < log_key.size(); k++) begin
         n_total++;
         if (log_key[k] != exp_k[k]) $display("FAIL b2b_beat%0d got=%h exp=%h", k, log_key[k], exp_k[k]);
         else n_pass++;
      end
      n_total++;
      if (cyc != 4) $display("FAIL b2b_cycles got=%0d exp=4", cyc); else n_pass++;
   endtask

   task automatic test_two_requesters();
      int cyc;
      int exp_k[6] = '{'h0A0, 'h0A1, 'h1B0, 'h1B1, 'h0A2, 'h0A3};
      do_reset();
      add_pkt(0, 2, 8'hA0, 8'h01);
      add_pkt(1, 2, 8'hB0, 8'h01);
      add_pkt(0, 2, 8'hA2, 8'h01);
      drain(100, 100, 100, cyc);
      n_total++;
      if (log_key.size() != 6) $display("FAIL two_req_count got=%0d exp=6", log_key.size()); else n_pass++;
      for (int k = 0; k < 6 && k < log_key.size(); k++) begin
         n_total++;
         if (log_key[k] != exp_k[k]) $display("FAIL two_req_beat%0d got=%h exp=%h", k, log_key[k], exp_k[k]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      int exp_k[6] = '{'h040, 'h041, 'h042, 'h043, 'h150, 'h151};
      do_reset();
      add_pkt(0, 4, 8'h40, 8'h01);
      add_pkt(1, 2, 8'h50, 8'h01);
      step(1'b1, 100);
      step(1'b1, 100);
      repeat (3) step(1'b0, 100);
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 8'h41)
         $display("FAIL stall_hold got=%b/%h exp=1/41", out_valid, out_data);
      else n_pass++;
      drain(100, 100, 100, cyc);
      n_total++;
      if (log_key.size() != 6) $display("FAIL bp_count got=%0d exp=6", log_key.size()); else n_pass++;
      for (int k = 0; k < 6 && k < log_key.size(); k++) begin
         n_total++;
         if (log_key[k] != exp_k[k]) $display("FAIL bp_beat%0d got=%h exp=%h", k, log_key[k], exp_k[k]);
         else n_pass++;
      end
   endtask

   task automatic test_single_beat_alternation();
      int cyc;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         add_pkt(0, 1, 8'(k), 8'h00);
         add_pkt(1, 1, 8'(8'h80 + k), 8'h00);
      end
      drain(100, 100, 100, cyc);
      n_total++;
      if (cyc != 9) $display("FAIL alt_throughput cycles got=%0d exp=9", cyc); else n_pass++;
      n_total++;
      if (log_key.size() != 8) $display("FAIL alt_count got=%0d exp=8", log_key.size()); else n_pass++;
      for (int k = 0; k < 8 && k < log_key.size(); k++) begin
         n_total++;
         if (log_key[k] / 256 != k % 2)
            $display("FAIL alt_channel%0d got=%0d exp=%0d", k, log_key[k] / 256, k % 2);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_packet();
      int cyc;
      int exp_k[2] = '{'h0D0, 'h1E0};
      do_reset();
      add_pkt(1, 4, 8'hC0, 8'h01);
      step(1'b1, 100);
      step(1'b1, 100);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_channel !== 8'h00)
         $display("FAIL async_reset_out got=%b/%h/%h exp=0/00/00", out_valid, out_data, out_channel);
      else n_pass++;
      n_total++;
      if (in_ready !== 4'h0) $display("FAIL async_reset_ready got=%b exp=0000", in_ready); else n_pass++;
      model_clear();
      in_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      add_pkt(0, 1, 8'hD0, 8'h00);
      add_pkt(1, 1, 8'hE0, 8'h00);
      drain(100, 100, 50, cyc);
      n_total++;
      if (log_key.size() != 2) $display("FAIL post_reset_count got=%0d exp=2", log_key.size()); else n_pass++;
      for (int k = 0; k < 2 && k < log_key.size(); k++) begin
         n_total++;
         if (log_key[k] != exp_k[k]) $display("FAIL post_reset_beat%0d got=%h exp=%h", k, log_key[k], exp_k[k]);
         else n_pass++;
      end
   endtask

   task automatic test_four_channel();
      int cyc;
      int exp_k[4] = '{'h390, 'h391, 'h170, 'h171};
      do_reset();
      add_pkt(1, 1, 8'h61, 8'h00);
      drain(100, 100, 50, cyc);
      log_key.delete();
      add_pkt(1, 2, 8'h70, 8'h01);
      add_pkt(3, 2, 8'h90, 8'h01);
      drain(100, 100, 50, cyc);
      n_total++;
      if (log_key.size() != 4) $display("FAIL four_ch_count got=%0d exp=4", log_key.size()); else n_pass++;
      for (int k = 0; k < 4 && k < log_key.size(); k++) begin
         n_total++;
         if (log_key[k] != exp_k[k]) $display("FAIL four_ch_beat%0d got=%h exp=%h", k, log_key[k], exp_k[k]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int cyc;
      int total;
      int ch;
      int len;
      logic [7:0] d;
      do_reset();
      total = 0;
      for (int p = 0; p < 60; p++) begin
         ch  = int'($urandom_range(3));
         len = int'($urandom_range(4, 1));
         for (int k = 0; k < len; k++) begin
            d = 8'($urandom);
            // occasional stray SOP mid-packet must pass straight through
            srcq[ch].push_back({(k == 0) || ($urandom_range(9) == 0), (k == len - 1), d});
         end
         total += len;
      end
      drain(70, 60, 5000, cyc);
      n_total++;
      if (log_key.size() != total) $display("FAIL random_count got=%0d exp=%0d", log_key.size(), total);
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      clk = 1'b0;
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_single_back_to_back();
      test_two_requesters();
      test_backpressure();
      test_single_beat_alternation();
      test_reset_mid_packet();
      test_four_channel();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
